// File: rtl/fpnew_slice_rr_arbiter.sv
// ----------------------------------------------------------------------------
// fpnew_slice_rr_arbiter
//
// Merges the result streams of NumSlices format slices of one operation group
// into a single registered result stream. A round-robin pointer selects the
// winning slice; the winner is accepted in the same cycle it is selected and
// lands in a one-entry output register on the next edge.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            asynchronous active-high reset
//   slice_valid_i    per-slice result valid
//   slice_ready_o    per-slice accept (one-hot or zero)
//   slice_result_i   per-slice result
//   slice_status_i   per-slice status flags (5 bits)
//   slice_ext_bit_i  per-slice extension bit
//   slice_tag_i      per-slice operation tag
//   slice_busy_i     per-slice busy
//   flush_i          synchronous flush, drops the output register contents
//   result_o         registered result
//   status_o         registered status
//   extension_bit_o  registered extension bit
//   tag_o            registered tag
//   out_valid_o      output register holds data
//   out_ready_i      downstream accepts
//   busy_o           data in flight in this block or any slice
// ----------------------------------------------------------------------------
module fpnew_slice_rr_arbiter #(
   parameter int unsigned NumSlices = 4,
   parameter int unsigned Width     = 64,
   parameter type         TagType   = logic
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [NumSlices-1:0]              slice_valid_i,
   output logic [NumSlices-1:0]              slice_ready_o,
   input  logic [NumSlices-1:0][Width-1:0]   slice_result_i,
   input  logic [NumSlices-1:0][4:0]         slice_status_i,
   input  logic [NumSlices-1:0]              slice_ext_bit_i,
   input  TagType [NumSlices-1:0]            slice_tag_i,
   input  logic [NumSlices-1:0]              slice_busy_i,
   input  logic                              flush_i,
   output logic [Width-1:0]                  result_o,
   output logic [4:0]                        status_o,
   output logic                              extension_bit_o,
   output TagType                            tag_o,
   output logic                              out_valid_o,
   input  logic                              out_ready_i,
   output logic                              busy_o
);

   // Pointer is at least one bit wide so NumSlices=1 still elaborates.
   localparam int unsigned PtrW  = (NumSlices > 1) ? $clog2(NumSlices) : 1;
   // Distance needs one extra bit so "no request" (distance NumSlices) fits.
   localparam int unsigned DistW = PtrW + 1;

   logic [PtrW-1:0]   ptr_q, ptr_d;
   logic              out_valid_q, out_valid_d;
   logic [Width-1:0]  result_q, result_d;
   logic [4:0]        status_q, status_d;
   logic              ext_bit_q, ext_bit_d;
   TagType            tag_q, tag_d;

   logic              any_req_s;
   logic              free_s;
   logic              load_s;
   logic [PtrW-1:0]   gnt_idx_s;
   logic [PtrW-1:0]   ptr_next_s;
   logic [DistW-1:0]  best_dist_s;
   logic [DistW-1:0]  dist_s;
   logic [DistW-1:0]  j_w_s;
   logic [DistW-1:0]  ptr_w_s;
   logic [Width-1:0]  sel_result_s;
   logic [4:0]        sel_status_s;
   logic              sel_ext_bit_s;
   TagType            sel_tag_s;
   logic [NumSlices-1:0] ready_s;

   // Round-robin search: each slice's priority is its distance from ptr,
   // computed modulo NumSlices so non-power-of-two counts wrap correctly.
   always_comb begin
      any_req_s   = |slice_valid_i;
      gnt_idx_s   = ptr_q;
      best_dist_s = DistW'(NumSlices);
      dist_s      = '0;
      j_w_s       = '0;
      ptr_w_s     = {1'b0, ptr_q};
      for (int unsigned j = 0; j < NumSlices; j++) begin
         j_w_s = DistW'(j);
         if (j_w_s >= ptr_w_s) begin
            dist_s = j_w_s - ptr_w_s;
         end else begin
            dist_s = j_w_s + DistW'(NumSlices) - ptr_w_s;
         end
         if (slice_valid_i[j] && (dist_s < best_dist_s)) begin
            best_dist_s = dist_s;
            gnt_idx_s   = j_w_s[PtrW-1:0];
         end else begin
            best_dist_s = best_dist_s;
         end
      end
   end

   // Handshake qualification, winner data mux and one-hot ready generation.
   always_comb begin
      free_s        = ~out_valid_q | out_ready_i;
      load_s        = any_req_s & free_s & ~flush_i;
      sel_result_s  = '0;
      sel_status_s  = '0;
      sel_ext_bit_s = 1'b0;
      sel_tag_s     = '0;
      ready_s       = '0;
      for (int unsigned j = 0; j < NumSlices; j++) begin
         if (gnt_idx_s == PtrW'(j)) begin
            sel_result_s  = slice_result_i[j];
            sel_status_s  = slice_status_i[j];
            sel_ext_bit_s = slice_ext_bit_i[j];
            sel_tag_s     = slice_tag_i[j];
            ready_s[j]    = load_s;
         end else begin
            ready_s[j]    = 1'b0;
         end
      end
   end

   // Pointer advance past the winner, with explicit wrap at NumSlices-1.
   always_comb begin
      if (gnt_idx_s == PtrW'(NumSlices - 1)) begin
         ptr_next_s = '0;
      end else begin
         ptr_next_s = gnt_idx_s + PtrW'(1);
      end
   end

   // Next-state for the output register; flush wins over pop and load,
   // and data fields only change on a load.
   always_comb begin
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      status_d    = status_q;
      ext_bit_d   = ext_bit_q;
      tag_d       = tag_q;
      if (flush_i) begin
         out_valid_d = 1'b0;
      end else if (load_s) begin
         out_valid_d = 1'b1;
         ptr_d       = ptr_next_s;
         result_d    = sel_result_s;
         status_d    = sel_status_s;
         ext_bit_d   = sel_ext_bit_s;
         tag_d       = sel_tag_s;
      end else if (out_ready_i) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         status_q    <= 5'b00000;
         ext_bit_q   <= 1'b0;
         tag_q       <= '0;
      end else begin
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         status_q    <= status_d;
         ext_bit_q   <= ext_bit_d;
         tag_q       <= tag_d;
      end
   end

   assign slice_ready_o   = ready_s;
   assign result_o        = result_q;
   assign status_o        = status_q;
   assign extension_bit_o = ext_bit_q;
   assign tag_o           = tag_q;
   assign out_valid_o     = out_valid_q;
   assign busy_o          = out_valid_q | (|slice_busy_i);

endmodule

// File: tb/tb_fpnew_slice_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fpnew_slice_rr_arbiter
//
// Directed bench for fpnew_slice_rr_arbiter with NumSlices=4, Width=64.
// Stimulus pushes the expected output record into a queue when a slice
// handshake is expected; a negedge monitor compares the output register
// against the queue head and pops it on each output handshake.
// ----------------------------------------------------------------------------
module tb_fpnew_slice_rr_arbiter;

   typedef struct packed {
      logic [63:0] res;
      logic [4:0]  st;
      logic        ext;
      logic        tag;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [3:0]       slice_valid_i;
   logic [3:0]       slice_ready_o;
   logic [3:0][63:0] slice_result_i;
   logic [3:0][4:0]  slice_status_i;
   logic [3:0]       slice_ext_bit_i;
   logic [3:0]       slice_tag_i;
   logic [3:0]       slice_busy_i;
   logic             flush_i;
   logic [63:0]      result_o;
   logic [4:0]       status_o;
   logic             extension_bit_o;
   logic             tag_o;
   logic             out_valid_o;
   logic             out_ready_i;
   logic             busy_o;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;

   fpnew_slice_rr_arbiter #(
      .NumSlices(4),
      .Width(64),
      .TagType(logic)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .slice_valid_i(slice_valid_i),
      .slice_ready_o(slice_ready_o),
      .slice_result_i(slice_result_i),
      .slice_status_i(slice_status_i),
      .slice_ext_bit_i(slice_ext_bit_i),
      .slice_tag_i(slice_tag_i),
      .slice_busy_i(slice_busy_i),
      .flush_i(flush_i),
      .result_o(result_o),
      .status_o(status_o),
      .extension_bit_o(extension_bit_o),
      .tag_o(tag_o),
      .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Distinct default payload per slice.
   task automatic init_slices();
      for (int i = 0; i < 4; i++) begin
         slice_result_i[i]  = 64'hC000_0000_0000_0000 | 64'(i * 16 + 1);
         slice_status_i[i]  = 5'(i + 2);
         slice_ext_bit_i[i] = i[0];
         slice_tag_i[i]     = i[1];
      end
   endtask

   function automatic exp_t slice_exp(input int i);
      exp_t e;
      e.res = slice_result_i[i];
      e.st  = slice_status_i[i];
      e.ext = slice_ext_bit_i[i];
      e.tag = slice_tag_i[i];
      return e;
   endfunction

   // Monitor: compare the output register with the queue head every cycle it
   // is valid (covers stall stability), pop on handshake.
   always @(negedge clk) begin
      if (!rst && out_valid_o) begin
         if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_out: got result %h, expected no output", result_o);
         end else begin
            chk("mon_result", result_o, q[0].res);
            chk("mon_status", 64'(status_o), 64'(q[0].st));
            chk("mon_ext", 64'(extension_bit_o), 64'(q[0].ext));
            chk("mon_tag", 64'(tag_o), 64'(q[0].tag));
            if (out_ready_i) begin
               void'(q.pop_front());
            end
         end
      end
   end

   logic [3:0] cont_rdy [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   int         cont_idx [5] = '{0, 1, 2, 3, 0};

   initial begin
      rst           = 1'b1;
      slice_valid_i = 4'b0000;
      slice_busy_i  = 4'b0000;
      flush_i       = 1'b0;
      out_ready_i   = 1'b1;
      init_slices();

      // Reset state and busy
      #1;
      chk("rst_out_valid", 64'(out_valid_o), 64'd0);
      chk("rst_result", result_o, 64'd0);
      chk("rst_ready", 64'(slice_ready_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      slice_busy_i = 4'b0100;
      #1;
      chk("busy_from_slice", 64'(busy_o), 64'd1);
      slice_busy_i = 4'b0000;
      @(negedge clk);
      rst = 1'b0;
      step();
      chk("idle_ready", 64'(slice_ready_o), 64'd0);
      chk("idle_busy", 64'(busy_o), 64'd0);

      // Single request from slice 2
      slice_result_i[2] = 64'h3FF0_0000_0000_0000;
      slice_status_i[2] = 5'b00001;
      slice_ext_bit_i[2] = 1'b0;
      slice_tag_i[2]    = 1'b1;
      slice_valid_i     = 4'b0100;
      #1;
      chk("single_ready", 64'(slice_ready_o), 64'h4);
      q.push_back('{res: 64'h3FF0_0000_0000_0000, st: 5'b00001, ext: 1'b0, tag: 1'b1});
      step();
      slice_valid_i = 4'b0000;
      chk("single_latency", 64'(out_valid_o), 64'd1);
      chk("single_busy", 64'(busy_o), 64'd1);
      step();
      chk("single_drained", 64'(out_valid_o), 64'd0);

      // Restart from ptr=0 for the contention sequence
      rst = 1'b1;
      #2;
      rst = 1'b0;
      init_slices();
      step();

      // Contention: all four valid, grant order 0,1,2,3,0
      slice_valid_i = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("cont_ready", 64'(slice_ready_o), 64'(cont_rdy[k]));
         q.push_back(slice_exp(cont_idx[k]));
         step();
      end
      slice_valid_i = 4'b0000;
      step();

      // Backpressure: ptr=1, slices 1 and 3 valid, downstream stalled 3 cycles
      out_ready_i   = 1'b0;
      slice_valid_i = 4'b1010;
      #1;
      chk("bp_first_ready", 64'(slice_ready_o), 64'h2);
      q.push_back(slice_exp(1));
      step();
      for (int k = 0; k < 3; k++) begin
         chk("bp_stall_ready", 64'(slice_ready_o), 64'd0);
         chk("bp_stall_valid", 64'(out_valid_o), 64'd1);
         step();
      end
      out_ready_i = 1'b1;
      #1;
      chk("bp_pop_load_ready", 64'(slice_ready_o), 64'h8);
      q.push_back(slice_exp(3));
      step();
      slice_valid_i = 4'b0000;
      chk("bp_refill_valid", 64'(out_valid_o), 64'd1);
      step();

      // Flush: output holds slice 0, slice 0 still valid
      out_ready_i   = 1'b0;
      slice_valid_i = 4'b0001;
      #1;
      chk("fl_load_ready", 64'(slice_ready_o), 64'h1);
      q.push_back(slice_exp(0));
      step();
      slice_result_i[0] = 64'h0123_4567_89AB_CDEF;
      flush_i = 1'b1;
      #1;
      chk("fl_ready_zero", 64'(slice_ready_o), 64'd0);
      @(negedge clk);
      #1;
      void'(q.pop_front());
      step();
      flush_i = 1'b0;
      chk("fl_valid_dropped", 64'(out_valid_o), 64'd0);
      out_ready_i = 1'b1;
      #1;
      chk("fl_regrant_slice0", 64'(slice_ready_o), 64'h1);
      q.push_back(slice_exp(0));
      step();
      slice_valid_i = 4'b0000;
      step();

      // Reset during a stall; ptr was 1, becomes 3 after granting slice 2
      out_ready_i   = 1'b0;
      slice_valid_i = 4'b0100;
      #1;
      chk("rs_load_ready", 64'(slice_ready_o), 64'h4);
      q.push_back(slice_exp(2));
      step();
      slice_valid_i = 4'b0000;
      #2;
      rst = 1'b1;
      #1;
      chk("rs_async_valid", 64'(out_valid_o), 64'd0);
      chk("rs_async_result", result_o, 64'd0);
      void'(q.pop_front());
      @(negedge clk);
      #1;
      rst = 1'b0;
      out_ready_i   = 1'b1;
      slice_valid_i = 4'b1010;
      #1;
      chk("rs_ptr_zero_grant", 64'(slice_ready_o), 64'h2);
      q.push_back(slice_exp(1));
      step();
      slice_valid_i = 4'b0000;

      // Drain with a bounded wait
      for (int k = 0; k < 20 && q.size() != 0; k++) begin
         step();
      end
      chk("drain_queue_empty", 64'(q.size()), 64'd0);
      step();
      chk("end_out_valid", 64'(out_valid_o), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fpnew_slice_rr_arbiter.md
Name: fpnew_slice_rr_arbiter

Overview:
- Merges the output streams of NumSlices format slices of one operation group into a single registered result stream.
- Arbitration is round-robin: the grant pointer advances past the last winner.
- Sits between the format slices and the opgroup output.
- Provides a one-entry output register, flush support and a combined busy indication.

Parameters:
- NumSlices, 4, number of requesting format slices (>=1).
- Width, 64, result width in bits.
- TagType, logic, type of the operation tag carried with each result.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous active-high reset.
- slice_valid_i  input  NumSlices  per-slice result valid.
- slice_ready_o  output  NumSlices  per-slice result accepted (one-hot or zero).
- slice_result_i  input  NumSlices x Width  per-slice result.
- slice_status_i  input  NumSlices x 5  per-slice fpnew_pkg::status_t.
- slice_ext_bit_i  input  NumSlices  per-slice extension bit.
- slice_tag_i  input  NumSlices x TagType  per-slice tag.
- slice_busy_i  input  NumSlices  per-slice busy.
- flush_i  input  1  synchronous flush.
- result_o  output  Width  registered result.
- status_o  output  5  registered status.
- extension_bit_o  output  1  registered extension bit.
- tag_o  output  TagType  registered tag.
- out_valid_o  output  1  output register holds data.
- out_ready_i  input  1  downstream accepts.
- busy_o  output  1  data in flight anywhere.

Behaviour:
- Reset (async on rst_i high):
  - out_valid_o=0; result_o, status_o, extension_bit_o and tag_o = 0.
  - Priority pointer ptr=0.
  - slice_ready_o follows the combinational rules below, evaluated with out_valid_o=0.
- Free condition: free = ~out_valid_o | out_ready_i.
- Arbitration (combinational):
  - Search indices ptr, ptr+1, ..., ptr+NumSlices-1 (mod NumSlices) for the first asserted slice_valid_i.
  - That index is g; any_req = |slice_valid_i.
- Load condition: load = any_req & free & ~flush_i.
- Ready outputs: slice_ready_o[g]=load; all other bits 0. All bits are 0 when flush_i=1 or when not free.
- On load, at the next edge:
  - The output register captures slice_result_i[g], slice_status_i[g], slice_ext_bit_i[g] and slice_tag_i[g].
  - out_valid_o<=1.
  - ptr<=(g+1) mod NumSlices.
- Pop without refill: if out_valid_o & out_ready_i & ~load, then out_valid_o<=0. The data registers hold their old values.
- Simultaneous pop and load: the register is replaced in the same cycle. This gives full throughput of 1 result/cycle.
- Latency: exactly 1 cycle from the accepted slice handshake to out_valid_o.
- Stall: while out_valid_o & ~out_ready_i, all output fields are held stable and slice_ready_o=0.
- ptr update rules:
  - ptr changes only on load.
  - ptr is unchanged on flush.
  - With NumSlices=1, ptr is constant 0.
- Flush (flush_i=1 at an edge):
  - out_valid_o<=0; no load occurs.
  - Flush overrides a simultaneous pop or load.
  - Data registers keep their values.
- busy_o = out_valid_o | (|slice_busy_i), combinational.
- Valid inputs are not required to be stable. The arbiter re-evaluates g every cycle; no grant lock, since acceptance happens in the same cycle as selection.
- Reset mid-stall: the registered result is discarded and out_valid_o=0 immediately (async).
- Pointer width: clog2(NumSlices), minimum 1 bit. Wrap from NumSlices-1 to 0 also holds for non-power-of-two NumSlices.

Test Plan:
- Reset, then idle, all valids 0 -> out_valid_o=0, slice_ready_o=4'b0000, busy_o=0. With slice_busy_i=4'b0100 -> busy_o=1.
- Single request:
  - Stimulus: slice 2 valid, result 64'h3FF0_0000_0000_0000, status 5'b00001, tag 1; out_ready_i=1.
  - Response: slice_ready_o=4'b0100 in the same cycle. Next cycle out_valid_o=1, result_o=64'h3FF0_0000_0000_0000, status_o=5'b00001, tag_o=1; ptr=3.
- Contention with all four valid continuously and out_ready_i=1 from ptr=0 -> grant order 0,1,2,3,0. One result per cycle; output order matches the grant order.
- Backpressure:
  - Stimulus: out_ready_i=0 for 3 cycles with slices 1 and 3 valid.
  - Response: the first result is held stable and slice_ready_o=0 during the stall. When out_ready_i rises, the pop and the load of the next winner happen in the same cycle.
- Flush:
  - Stimulus: out_valid_o=1, slice 0 valid, flush_i=1 for one cycle.
  - Response: slice_ready_o=0 that cycle, out_valid_o=0 next cycle, ptr unchanged. The following cycle, slice 0 is granted.
- Reset asserted while out_valid_o=1 and out_ready_i=0 -> out_valid_o drops to 0 without waiting for a clock edge; ptr=0 after release.
